// File: rtl/shift_req_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | shift_req_arbiter : two-requester round-robin sequencer for an 8-bit        |
// |                     rotate-left/right barrel shifter.                       |
// | Optional grant counters: define SHIFT_ARB_STATS_EN.                         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+

module improvedMultiFun_barrelShifter #(
  parameter int DATA_W = 8,
  parameter int AMT_W  = 3
) (
  input  logic [DATA_W-1:0] num_i,
  input  logic [AMT_W-1:0]  amt_i,
  input  logic              lr_i,
  output logic [DATA_W-1:0] y_o
);

  logic [DATA_W-1:0] w_stg [0:AMT_W];

  assign w_stg[0] = num_i;

  // Log-depth rotator: stage s rotates by 2^s when amt bit s is set.
  for (genvar s = 0; s < AMT_W; s++) begin : g_stage
    localparam int K = 1 << s;
    logic [DATA_W-1:0] w_rol;
    logic [DATA_W-1:0] w_ror;
    assign w_rol = {w_stg[s][DATA_W-1-K:0], w_stg[s][DATA_W-1:DATA_W-K]};
    assign w_ror = {w_stg[s][K-1:0], w_stg[s][DATA_W-1:K]};
    assign w_stg[s+1] = amt_i[s] ? (lr_i ? w_ror : w_rol) : w_stg[s];
  end

  assign y_o = w_stg[AMT_W];

endmodule

module shift_req_arbiter #(
  parameter int DATA_W = 8,
  parameter int AMT_W  = 3
`ifdef SHIFT_ARB_STATS_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_num,
  input  logic [AMT_W-1:0]  req0_amt,
  input  logic              req0_lr,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_num,
  input  logic [AMT_W-1:0]  req1_amt,
  input  logic              req1_lr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_num,
  output logic              busy
`ifdef SHIFT_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  grant0_cnt,
  output logic [CNT_W-1:0]  grant1_cnt
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] op_num_q, op_num_d;
  logic [AMT_W-1:0]  op_amt_q, op_amt_d;
  logic              op_lr_q, op_lr_d;
  logic              op_id_q, op_id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_num_q, rsp_num_d;

  logic              w_idle;
  logic              w_win;
  logic              w_acc;
  logic [DATA_W-1:0] w_shift;

  improvedMultiFun_barrelShifter #(
    .DATA_W (DATA_W),
    .AMT_W  (AMT_W)
  ) u_shifter (
    .num_i (op_num_q),
    .amt_i (op_amt_q),
    .lr_i  (op_lr_q),
    .y_o   (w_shift)
  );

  assign w_idle = (state_q == S_IDLE) && !reset;
  // Contention goes to whoever did not win last; otherwise the sole requester.
  assign w_win  = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
  assign w_acc  = w_idle && (req0_valid || req1_valid);

  assign req0_ready = w_acc && !w_win;
  assign req1_ready = w_acc && w_win;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_num_d     = op_num_q;
    op_amt_d     = op_amt_q;
    op_lr_d      = op_lr_q;
    op_id_d      = op_id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_num_d    = rsp_num_q;
    case (state_q)
      S_IDLE: begin
        if (w_acc) begin
          op_num_d     = w_win ? req1_num : req0_num;
          op_amt_d     = w_win ? req1_amt : req0_amt;
          op_lr_d      = w_win ? req1_lr  : req0_lr;
          op_id_d      = w_win;
          last_grant_d = w_win;
          state_d      = S_EXEC;
        end
      end
      S_EXEC: begin
        rsp_num_d   = w_shift;
        rsp_id_d    = op_id_q;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      op_num_q     <= '0;
      op_amt_q     <= '0;
      op_lr_q      <= 1'b0;
      op_id_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_num_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_num_q     <= op_num_d;
      op_amt_q     <= op_amt_d;
      op_lr_q      <= op_lr_d;
      op_id_q      <= op_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_num_q    <= rsp_num_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_num   = rsp_num_q;
  assign busy      = (state_q != S_IDLE);

`ifdef SHIFT_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  assign cnt0_d = req0_ready ? cnt0_q + 1'b1 : cnt0_q;
  assign cnt1_d = req1_ready ? cnt1_q + 1'b1 : cnt1_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant0_cnt = cnt0_q;
  assign grant1_cnt = cnt1_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_shift_req_arbiter.sv
`default_nettype none
// Directed bench for shift_req_arbiter: vector table plus hand-written
// sequences for arbitration, back-pressure and mid-job reset.
module tb_shift_req_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req0_ready, req0_lr;
  logic [7:0] req0_num;
  logic [2:0] req0_amt;
  logic       req1_valid, req1_ready, req1_lr;
  logic [7:0] req1_num;
  logic [2:0] req1_amt;
  logic       rsp_valid, rsp_ready, rsp_id, busy;
  logic [7:0] rsp_num;
`ifdef SHIFT_ARB_STATS_EN
  logic [15:0] grant0_cnt, grant1_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_req_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_num   (req0_num),
    .req0_amt   (req0_amt),
    .req0_lr    (req0_lr),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_num   (req1_num),
    .req1_amt   (req1_amt),
    .req1_lr    (req1_lr),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_num    (rsp_num),
    .busy       (busy)
`ifdef SHIFT_ARB_STATS_EN
    ,
    .grant0_cnt (grant0_cnt),
    .grant1_cnt (grant1_cnt)
`endif
  );

  typedef struct {
    logic       id;
    logic [7:0] num;
    logic [2:0] amt;
    logic       lr;
    logic [7:0] exp;
    int         hold;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic rdy_of(input logic id);
    return id ? req1_ready : req0_ready;
  endfunction

  // Runs one single-requester job from IDLE; called at a negedge, returns at a negedge in IDLE.
  task automatic do_job(input vec_t v);
    int waited;
    if (v.id == 1'b0) begin
      req0_valid = 1'b1; req0_num = v.num; req0_amt = v.amt; req0_lr = v.lr;
    end else begin
      req1_valid = 1'b1; req1_num = v.num; req1_amt = v.amt; req1_lr = v.lr;
    end
    #1;
    waited = 0;
    while (rdy_of(v.id) !== 1'b1 && waited < 4) begin
      @(negedge clk); #1;
      waited++;
    end
    chk("accept_ready", {31'd0, rdy_of(v.id)}, 1);
    chk("loser_ready", {31'd0, rdy_of(!v.id)}, 0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk("exec_busy", {31'd0, busy}, 1);
    chk("exec_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("exec_ready", {30'd0, req0_ready, req1_ready}, 0);
    @(negedge clk); #1;
    chk("rsp_valid", {31'd0, rsp_valid}, 1);
    chk("rsp_num", {24'd0, rsp_num}, {24'd0, v.exp});
    chk("rsp_id", {31'd0, rsp_id}, {31'd0, v.id});
    for (int i = 0; i < v.hold; i++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      @(negedge clk); #1;
      chk("hold_valid", {31'd0, rsp_valid}, 1);
      chk("hold_num", {24'd0, rsp_num}, {24'd0, v.exp});
      chk("hold_id", {31'd0, rsp_id}, {31'd0, v.id});
      chk("hold_ready", {30'd0, req0_ready, req1_ready}, 0);
      chk("hold_busy", {31'd0, busy}, 1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("idle_busy", {31'd0, busy}, 0);
    chk("idle_rsp_valid", {31'd0, rsp_valid}, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, 8'h01, 3'd3, 1'b0, 8'h08, 0};
    tbl[1] = '{1'b1, 8'h59, 3'd1, 1'b1, 8'hAC, 0};
    tbl[2] = '{1'b0, 8'hA5, 3'd0, 1'b0, 8'hA5, 0};
    tbl[3] = '{1'b1, 8'hA5, 3'd0, 1'b1, 8'hA5, 1};
    tbl[4] = '{1'b0, 8'h81, 3'd1, 1'b0, 8'h03, 5};
    tbl[5] = '{1'b1, 8'h81, 3'd7, 1'b1, 8'h03, 0};
    tbl[6] = '{1'b0, 8'hF0, 3'd4, 1'b1, 8'h0F, 0};
    tbl[7] = '{1'b1, 8'h3C, 3'd2, 1'b0, 8'hF0, 0};

    reset = 1'b1;
    req0_valid = 1'b0; req0_num = '0; req0_amt = '0; req0_lr = 1'b0;
    req1_valid = 1'b0; req1_num = '0; req1_amt = '0; req1_lr = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("rst_rsp_id", {31'd0, rsp_id}, 0);
    chk("rst_rsp_num", {24'd0, rsp_num}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ready", {30'd0, req0_ready, req1_ready}, 0);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < 8; i++) do_job(tbl[i]);

    // Both requesters contending right after reset: req0, then req1, then req0.
    pulse_reset();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_num = 8'h07; req0_amt = 3'd7; req0_lr = 1'b0;
    req1_valid = 1'b1; req1_num = 8'h40; req1_amt = 3'd3; req1_lr = 1'b1;
    #1;
    chk("arb1_req0_ready", {31'd0, req0_ready}, 1);
    chk("arb1_req1_ready", {31'd0, req1_ready}, 0);
    @(negedge clk); req0_valid = 1'b0; #1;
    chk("arb1_exec_ready", {30'd0, req0_ready, req1_ready}, 0);
    @(negedge clk); #1;
    chk("arb1_rsp_num", {24'd0, rsp_num}, 32'h83);
    chk("arb1_rsp_id", {31'd0, rsp_id}, 0);
    @(negedge clk); #1;
    chk("arb2_req1_ready", {31'd0, req1_ready}, 1);
    chk("arb2_req0_ready", {31'd0, req0_ready}, 0);
    @(negedge clk); req1_valid = 1'b0;
    @(negedge clk); #1;
    chk("arb2_rsp_num", {24'd0, rsp_num}, 32'h08);
    chk("arb2_rsp_id", {31'd0, rsp_id}, 1);
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("arb3_req0_ready", {31'd0, req0_ready}, 1);
    chk("arb3_req1_ready", {31'd0, req1_ready}, 0);
    @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); #1;
    chk("arb3_rsp_num", {24'd0, rsp_num}, 32'h83);
    chk("arb3_rsp_id", {31'd0, rsp_id}, 0);
    @(negedge clk); rsp_ready = 1'b0; #1;
    chk("arb3_idle", {31'd0, busy}, 0);

    // Reset while a req0 job is in EXEC: job vanishes, req0 wins next contention.
    req0_valid = 1'b1; req0_num = 8'h01; req0_amt = 3'd3; req0_lr = 1'b0;
    #1;
    chk("rst_exec_accept", {31'd0, req0_ready}, 1);
    @(negedge clk); req0_valid = 1'b0; #1;
    chk("rst_exec_busy_pre", {31'd0, busy}, 1);
    reset = 1'b1; #1;
    chk("rst_exec_busy", {31'd0, busy}, 0);
    chk("rst_exec_rsp_num", {24'd0, rsp_num}, 0);
    chk("rst_exec_rsp_valid", {31'd0, rsp_valid}, 0);
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("rst_no_rsp", {31'd0, rsp_valid}, 0);
    end
    req0_valid = 1'b1; req0_num = 8'h07; req0_amt = 3'd7; req0_lr = 1'b0;
    req1_valid = 1'b1; req1_num = 8'h40; req1_amt = 3'd3; req1_lr = 1'b1;
    #1;
    chk("rst_arb_req0_ready", {31'd0, req0_ready}, 1);
    chk("rst_arb_req1_ready", {31'd0, req1_ready}, 0);
    @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); #1;
    chk("rst_arb_rsp_num", {24'd0, rsp_num}, 32'h83);
    rsp_ready = 1'b1;
    @(negedge clk); rsp_ready = 1'b0;

`ifdef SHIFT_ARB_STATS_EN
    pulse_reset();
    #1;
    chk("cnt0_reset", {16'd0, grant0_cnt}, 0);
    chk("cnt1_reset", {16'd0, grant1_cnt}, 0);
    for (int i = 0; i < 5; i++) do_job(tbl[(i < 3) ? 0 : 1]);
    chk("cnt0_after", {16'd0, grant0_cnt}, 3);
    chk("cnt1_after", {16'd0, grant1_cnt}, 2);
    pulse_reset();
    #1;
    chk("cnt0_cleared", {16'd0, grant0_cnt}, 0);
    chk("cnt1_cleared", {16'd0, grant1_cnt}, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
